// File: rtl/bus_mux_arbiter.sv
// Round-robin arbiter for a shared 2-to-1 datapath mux, with a registered valid/ready output stage.
// Optional burst limit compiled in with `define BUS_ARB_BURST_LIMIT_EN (MAX_BURST beats per grant).
module bus_mux_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int DATA_W    = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Req_A,
  input  logic [DATA_W-1:0] Data_A,
  input  logic              Last_A,
  input  logic              Req_B,
  input  logic [DATA_W-1:0] Data_B,
  input  logic              Last_B,
  output logic              Grant_A,
  output logic              Grant_B,
  output logic              Ack_A,
  output logic              Ack_B,
  output logic              Sel,
  output logic [DATA_W-1:0] Out_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready
);

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_max_burst_range
    $error("bus_mux_arbiter: MAX_BURST must be within 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              pref_b_q, pref_b_d;   // 0: A wins a tie, 1: B wins a tie
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic              space;
  logic              ack;
  logic              ack_last;
  logic [DATA_W-1:0] ack_data;
  logic              limit_hit;
  logic              release_grant;

  assign Grant_A   = (state_q == GNT_A);
  assign Grant_B   = (state_q == GNT_B);
  assign Sel       = Grant_A;
  assign Out_Data  = out_data_q;
  assign Out_Valid = out_valid_q;

  assign space         = !out_valid_q || Out_Ready;
  assign Ack_A         = Grant_A && Req_A && space;
  assign Ack_B         = Grant_B && Req_B && space;
  assign ack           = Ack_A || Ack_B;
  assign ack_data      = Ack_A ? Data_A : Data_B;
  assign ack_last      = Ack_A ? Last_A : Last_B;
  assign release_grant = ack && (ack_last || limit_hit);

`ifdef BUS_ARB_BURST_LIMIT_EN
  localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

  logic [7:0] beat_cnt_q, beat_cnt_d;

  // The beat that brings the count to MAX_BURST ends the grant.
  assign limit_hit = ack && (beat_cnt_q == MaxBurst - 8'd1);

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (release_grant) begin
      beat_cnt_d = 8'd0;
    end else if (ack && (beat_cnt_q != MaxBurst)) begin
      beat_cnt_d = beat_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      beat_cnt_q <= 8'd0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pref_b_d = pref_b_q;
    case (state_q)
      IDLE: begin
        if (Req_A && Req_B) begin
          state_d = pref_b_q ? GNT_B : GNT_A;
        end else if (Req_A) begin
          state_d = GNT_A;
        end else if (Req_B) begin
          state_d = GNT_B;
        end
      end
      GNT_A: begin
        if (release_grant) begin
          pref_b_d = 1'b1;
          state_d  = Req_B ? GNT_B : IDLE;
        end
      end
      GNT_B: begin
        if (release_grant) begin
          pref_b_d = 1'b0;
          state_d  = Req_A ? GNT_A : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (ack) begin
      out_data_d  = ack_data;
      out_valid_d = 1'b1;
    end else if (Out_Ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      pref_b_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pref_b_q    <= pref_b_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// Directed bench for bus_mux_arbiter: reset, round-robin, backpressure, burst limit, async reset, stalls.
module tb_bus_mux_arbiter;
  localparam int DATA_W = 16;
`ifdef BUS_ARB_BURST_LIMIT_EN
  localparam int NBeats = 4;
`else
  localparam int NBeats = 10;
`endif

  logic              Clock = 1'b0;
  logic              Resetn;
  logic              Req_A, Last_A, Req_B, Last_B, Out_Ready;
  logic [DATA_W-1:0] Data_A, Data_B;
  logic              Grant_A, Grant_B, Ack_A, Ack_B, Sel, Out_Valid;
  logic [DATA_W-1:0] Out_Data;

  int total = 0;
  int bad   = 0;

  bus_mux_arbiter #(.MAX_BURST(4), .DATA_W(DATA_W)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .Req_A(Req_A), .Data_A(Data_A), .Last_A(Last_A),
    .Req_B(Req_B), .Data_B(Data_B), .Last_B(Last_B),
    .Grant_A(Grant_A), .Grant_B(Grant_B), .Ack_A(Ack_A), .Ack_B(Ack_B),
    .Sel(Sel), .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready)
  );

  always #5 Clock = ~Clock;

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_reset();
    Req_A = 0; Req_B = 0; Last_A = 0; Last_B = 0; Data_A = '0; Data_B = '0; Out_Ready = 1;
    Resetn = 0;
    step();
    step();
    Resetn = 1;
    #1;
  endtask

  task automatic test_reset();
    Req_A = 0; Req_B = 0; Last_A = 0; Last_B = 0; Data_A = '0; Data_B = '0; Out_Ready = 1;
    Resetn = 0;
    #2;
    total++; if ({Grant_A, Grant_B, Sel, Ack_A, Ack_B, Out_Valid} !== 6'b0) begin bad++;
      $display("FAIL reset_ctrl got=%b exp=000000", {Grant_A, Grant_B, Sel, Ack_A, Ack_B, Out_Valid}); end
    total++; if (Out_Data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", Out_Data); end
    step();
    Resetn = 1;
  endtask

  task automatic test_single();
    Req_A = 1; Data_A = 16'h0002; Last_A = 1;
    #1;
    total++; if (Grant_A !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", Grant_A); end
    step();
    total++; if ({Grant_A, Sel, Ack_A, Grant_B} !== 4'b1110) begin bad++;
      $display("FAIL single_grant got=%b exp=1110", {Grant_A, Sel, Ack_A, Grant_B}); end
    step();
    Req_A = 0; Last_A = 0;
    #1;
    total++; if ({Out_Valid, Out_Data} !== {1'b1, 16'h0002}) begin bad++;
      $display("FAIL single_out got=%b/%h exp=1/0002", Out_Valid, Out_Data); end
    total++; if (Grant_A !== 1'b0) begin bad++; $display("FAIL single_release got=%b exp=0", Grant_A); end
  endtask

  task automatic test_round_robin();
    logic exp_a;
    apply_reset();
    Req_A = 1; Req_B = 1; Last_A = 1; Last_B = 1; Data_A = 16'h0002; Data_B = 16'h0003;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_a = (i % 2 == 0);
      total++; if ({Grant_A, Grant_B, Sel} !== {exp_a, !exp_a, exp_a}) begin bad++;
        $display("FAIL rr_grant i=%0d got=%b exp=%b", i, {Grant_A, Grant_B, Sel}, {exp_a, !exp_a, exp_a}); end
      total++; if ({Ack_A, Ack_B} !== {exp_a, !exp_a}) begin bad++;
        $display("FAIL rr_ack i=%0d got=%b exp=%b", i, {Ack_A, Ack_B}, {exp_a, !exp_a}); end
      if (i > 0) begin
        total++; if ({Out_Valid, Out_Data} !== {1'b1, exp_a ? 16'h0003 : 16'h0002}) begin bad++;
          $display("FAIL rr_data i=%0d got=%b/%h exp=1/%h", i, Out_Valid, Out_Data, exp_a ? 16'h0003 : 16'h0002); end
      end
    end
    Req_A = 0;
    step();
    Req_B = 0;
    total++; if ({Grant_A, Grant_B, Out_Data} !== {2'b00, 16'h0003}) begin bad++;
      $display("FAIL rr_end got=%b%b/%h exp=00/0003", Grant_A, Grant_B, Out_Data); end
  endtask

  task automatic test_backpressure();
    logic [7:0] rdy_tab = 8'b1111_0001;
    logic [7:0] ack_tab = 8'b0111_0001;
    int k = 0;
    int rx = 0;
    Req_A = 1; Data_A = 16'h0002; Last_A = 0; Out_Ready = 1;
    step();
    for (int c = 0; c < 8; c++) begin
      Req_A = (c < 7); Data_A = 16'(2 + k); Last_A = (k == 3); Out_Ready = rdy_tab[c];
      #1;
      total++; if (Ack_A !== ack_tab[c]) begin bad++; $display("FAIL bp_ack c=%0d got=%b exp=%b", c, Ack_A, ack_tab[c]); end
      if (c >= 1 && c <= 3) begin
        total++; if ({Out_Valid, Out_Data} !== {1'b1, 16'h0002}) begin bad++;
          $display("FAIL bp_hold c=%0d got=%b/%h exp=1/0002", c, Out_Valid, Out_Data); end
      end
      if (Out_Valid && Out_Ready) begin
        total++; if (Out_Data !== 16'(2 + rx)) begin bad++;
          $display("FAIL bp_order rx=%0d got=%h exp=%h", rx, Out_Data, 16'(2 + rx)); end
        rx++;
      end
      if (ack_tab[c]) k++;
      step();
    end
    Last_A = 0;
    total++; if (rx !== 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", rx); end
    total++; if ({Grant_A, Out_Valid} !== 2'b00) begin bad++; $display("FAIL bp_end got=%b exp=00", {Grant_A, Out_Valid}); end
  endtask

  task automatic test_burst_limit();
    apply_reset();
    Req_A = 1; Req_B = 1; Last_A = 0; Last_B = 1; Data_A = 16'h0010; Data_B = 16'h0055;
    step();
    for (int c = 0; c < NBeats; c++) begin
      Data_A = 16'(16'h0010 + c); Last_A = (c == 9);
      #1;
      total++; if ({Grant_A, Grant_B, Ack_A} !== 3'b101) begin bad++;
        $display("FAIL burst_beat c=%0d got=%b exp=101", c, {Grant_A, Grant_B, Ack_A}); end
      step();
    end
    Last_A = 0; Req_A = 0;
    total++; if ({Grant_A, Grant_B, Sel, Ack_B} !== 4'b0101) begin bad++;
      $display("FAIL burst_handoff got=%b exp=0101", {Grant_A, Grant_B, Sel, Ack_B}); end
    total++; if (Out_Data !== 16'(16'h0010 + NBeats - 1)) begin bad++;
      $display("FAIL burst_last_data got=%h exp=%h", Out_Data, 16'(16'h0010 + NBeats - 1)); end
    step();
    Req_B = 0;
    total++; if (Out_Data !== 16'h0055) begin bad++; $display("FAIL burst_b_data got=%h exp=0055", Out_Data); end
  endtask

  task automatic test_reset_mid_burst();
    Req_B = 1; Data_B = 16'h0077; Last_B = 0;
    step();
    step();
    total++; if ({Grant_B, Out_Valid, Out_Data} !== {2'b11, 16'h0077}) begin bad++;
      $display("FAIL rst_setup got=%b%b/%h exp=11/0077", Grant_B, Out_Valid, Out_Data); end
    Resetn = 0;
    #1;
    total++; if ({Grant_A, Grant_B, Sel, Out_Valid, Ack_B} !== 5'b0) begin bad++;
      $display("FAIL rst_async got=%b exp=00000", {Grant_A, Grant_B, Sel, Out_Valid, Ack_B}); end
    total++; if (Out_Data !== 16'h0000) begin bad++; $display("FAIL rst_async_data got=%h exp=0000", Out_Data); end
    step();
    Req_A = 1; Req_B = 1; Last_A = 1; Last_B = 1; Data_A = 16'h00A1; Data_B = 16'h00B1;
    Resetn = 1;
    #1;
    total++; if ({Grant_A, Grant_B} !== 2'b00) begin bad++; $display("FAIL rst_no_early got=%b exp=00", {Grant_A, Grant_B}); end
    step();
    total++; if ({Grant_A, Grant_B, Sel} !== 3'b101) begin bad++;
      $display("FAIL rst_tie_a got=%b exp=101", {Grant_A, Grant_B, Sel}); end
    step();
    Req_A = 0;
    total++; if ({Grant_B, Out_Data} !== {1'b1, 16'h00A1}) begin bad++;
      $display("FAIL rst_then_b got=%b/%h exp=1/00a1", Grant_B, Out_Data); end
    step();
    Req_B = 0;
  endtask

  task automatic test_stall();
    logic [3:0] req_tab = 4'b1001;
    logic [3:0] ack_tab = 4'b1001;
    Req_A = 1; Req_B = 1; Last_A = 0; Last_B = 1; Data_A = 16'h0020; Data_B = 16'h0099;
    step();
    for (int c = 0; c < 4; c++) begin
      Req_A = req_tab[c]; Last_A = (c == 3); Data_A = (c == 3) ? 16'h0021 : 16'h0020;
      #1;
      total++; if ({Grant_A, Grant_B, Ack_A, Ack_B} !== {2'b10, ack_tab[c], 1'b0}) begin bad++;
        $display("FAIL stall c=%0d got=%b exp=%b", c, {Grant_A, Grant_B, Ack_A, Ack_B}, {2'b10, ack_tab[c], 1'b0}); end
      step();
    end
    Req_A = 0; Last_A = 0;
    total++; if ({Grant_B, Out_Data} !== {1'b1, 16'h0021}) begin bad++;
      $display("FAIL stall_resume got=%b/%h exp=1/0021", Grant_B, Out_Data); end
    step();
    Req_B = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_burst_limit();
    test_reset_mid_burst();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
